// File: rtl/id_ex_stage_reg_if.sv
// ID->EX boundary bundle: decode controls, operands and hazard strobes in, registered EX entry out.
interface id_ex_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
);
  logic              id_valid;
  logic              stall;
  logic              bubble;
  logic              flush;
  logic              ALUSrc;
  logic              MemtoReg;
  logic              RegWrite;
  logic              MemRead;
  logic              MemWrite;
  logic              JalrSel;
  logic              jal_signal;
  logic              Branch;
  logic [1:0]        UIOp;
  logic [1:0]        ALUOp;
  logic [PC_W-1:0]   id_pc;
  logic [DATA_W-1:0] id_rd1;
  logic [DATA_W-1:0] id_rd2;
  logic [DATA_W-1:0] id_imm;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic [2:0]        id_funct3;
  logic [6:0]        id_funct7;

  logic              ex_valid;
  logic              ex_ALUSrc;
  logic              ex_MemtoReg;
  logic              ex_RegWrite;
  logic              ex_MemRead;
  logic              ex_MemWrite;
  logic              ex_JalrSel;
  logic              ex_jal_signal;
  logic              ex_Branch;
  logic [1:0]        ex_UIOp;
  logic [1:0]        ex_ALUOp;
  logic [PC_W-1:0]   ex_pc;
  logic [DATA_W-1:0] ex_rd1;
  logic [DATA_W-1:0] ex_rd2;
  logic [DATA_W-1:0] ex_imm;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [4:0]        ex_rd;
  logic [2:0]        ex_funct3;
  logic [6:0]        ex_funct7;

  modport master (
    output id_valid, stall, bubble, flush,
    output ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, JalrSel, jal_signal, Branch, UIOp, ALUOp,
    output id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd, id_funct3, id_funct7,
    input  ex_valid, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite,
    input  ex_JalrSel, ex_jal_signal, ex_Branch, ex_UIOp, ex_ALUOp,
    input  ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7
  );

  modport slave (
    input  id_valid, stall, bubble, flush,
    input  ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, JalrSel, jal_signal, Branch, UIOp, ALUOp,
    input  id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd, id_funct3, id_funct7,
    output ex_valid, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite,
    output ex_JalrSel, ex_jal_signal, ex_Branch, ex_UIOp, ex_ALUOp,
    output ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with stall/bubble/flush and saturating squash counters; 1-cycle latency.
// Stall holds the whole stage (counters too); flush beats stall, stall beats bubble.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  id_ex_stage_reg_if.slave bus,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       alu_src;
    logic       memto_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       jalr_sel;
    logic       jal;
    logic       branch;
    logic [1:0] ui_op;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
  } data_t;

  ctrl_t id_ctrl;
  ctrl_t ctrl_q;
  data_t id_data;
  data_t data_q;
  logic  valid_q;
  logic  flush_evt;
  logic  bubble_evt;

  // Controls of a non-valid ID slot are zeroed here so nothing from it can ever reach EX.
  always_comb begin
    id_ctrl = '0;
    if (bus.id_valid) begin
      id_ctrl.alu_src   = bus.ALUSrc;
      id_ctrl.memto_reg = bus.MemtoReg;
      id_ctrl.reg_write = bus.RegWrite;
      id_ctrl.mem_read  = bus.MemRead;
      id_ctrl.mem_write = bus.MemWrite;
      id_ctrl.jalr_sel  = bus.JalrSel;
      id_ctrl.jal       = bus.jal_signal;
      id_ctrl.branch    = bus.Branch;
      id_ctrl.ui_op     = bus.UIOp;
      id_ctrl.alu_op    = bus.ALUOp;
    end
  end

  always_comb begin
    id_data        = '0;
    id_data.pc     = bus.id_pc;
    id_data.rd1    = bus.id_rd1;
    id_data.rd2    = bus.id_rd2;
    id_data.imm    = bus.id_imm;
    id_data.rs1    = bus.id_rs1;
    id_data.rs2    = bus.id_rs2;
    id_data.rd     = bus.id_rd;
    id_data.funct3 = bus.id_funct3;
    id_data.funct7 = bus.id_funct7;
  end

  // A bubble only counts when it actually lands; flush or stall swallow it.
  assign flush_evt  = bus.flush;
  assign bubble_evt = !bus.flush && !bus.stall && bus.bubble;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (flush_evt || bubble_evt) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (!bus.stall) begin
      valid_q <= bus.id_valid;
      ctrl_q  <= id_ctrl;
      data_q  <= id_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (flush_evt && !(&flush_cnt)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
      if (bubble_evt && !(&bubble_cnt)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.ex_valid      = valid_q;
  assign bus.ex_ALUSrc     = ctrl_q.alu_src;
  assign bus.ex_MemtoReg   = ctrl_q.memto_reg;
  assign bus.ex_RegWrite   = ctrl_q.reg_write;
  assign bus.ex_MemRead    = ctrl_q.mem_read;
  assign bus.ex_MemWrite   = ctrl_q.mem_write;
  assign bus.ex_JalrSel    = ctrl_q.jalr_sel;
  assign bus.ex_jal_signal = ctrl_q.jal;
  assign bus.ex_Branch     = ctrl_q.branch;
  assign bus.ex_UIOp       = ctrl_q.ui_op;
  assign bus.ex_ALUOp      = ctrl_q.alu_op;
  assign bus.ex_pc         = data_q.pc;
  assign bus.ex_rd1        = data_q.rd1;
  assign bus.ex_rd2        = data_q.rd2;
  assign bus.ex_imm        = data_q.imm;
  assign bus.ex_rs1        = data_q.rs1;
  assign bus.ex_rs2        = data_q.rs2;
  assign bus.ex_rd         = data_q.rd;
  assign bus.ex_funct3     = data_q.funct3;
  assign bus.ex_funct7     = data_q.funct7;

  a_nop_no_side_effect : assert property (@(posedge clk) disable iff (!reset)
    !valid_q |-> !(ctrl_q.reg_write || ctrl_q.mem_read || ctrl_q.mem_write ||
                   ctrl_q.branch || ctrl_q.jalr_sel || ctrl_q.jal));

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed-vector bench for id_ex_stage_reg: expectations queued at issue, checked by a separate monitor.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [11:0] ctrl;  // {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,JalrSel,jal,Branch,UIOp,ALUOp}
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } stage_t;

  typedef struct packed {
    stage_t     st;
    logic [3:0] bc;
    logic [3:0] fc;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] bubble_cnt;
  logic [3:0] flush_cnt;
  int         cyc = 0;
  int         chk_cnt = 0;
  int         pass_cnt = 0;

  obs_t  exp_q[$];
  int    tag_q[$];
  string nm_q[$];

  id_ex_stage_reg_if #(.DATA_W(32), .PC_W(32)) bus ();

  id_ex_stage_reg #(.DATA_W(32), .PC_W(32), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic stage_t mk(logic v, logic [11:0] c, logic [31:0] pc, logic [31:0] rd1,
                                logic [31:0] rd2, logic [31:0] imm, logic [4:0] rs1,
                                logic [4:0] rs2, logic [4:0] rd, logic [2:0] f3, logic [6:0] f7);
    stage_t s;
    s.valid = v; s.ctrl = c; s.pc = pc; s.rd1 = rd1; s.rd2 = rd2; s.imm = imm;
    s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.f3 = f3; s.f7 = f7;
    return s;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st.valid = bus.ex_valid;
    o.st.ctrl  = {bus.ex_ALUSrc, bus.ex_MemtoReg, bus.ex_RegWrite, bus.ex_MemRead, bus.ex_MemWrite,
                  bus.ex_JalrSel, bus.ex_jal_signal, bus.ex_Branch, bus.ex_UIOp, bus.ex_ALUOp};
    o.st.pc  = bus.ex_pc;  o.st.rd1 = bus.ex_rd1; o.st.rd2 = bus.ex_rd2; o.st.imm = bus.ex_imm;
    o.st.rs1 = bus.ex_rs1; o.st.rs2 = bus.ex_rs2; o.st.rd  = bus.ex_rd;
    o.st.f3  = bus.ex_funct3; o.st.f7 = bus.ex_funct7;
    o.bc = bubble_cnt;
    o.fc = flush_cnt;
    return o;
  endfunction

  // Drive one cycle of inputs and queue the state expected right after the next rising edge.
  task automatic step(string nm, stage_t v, logic rs, logic fl, logic st, logic bu,
                      stage_t e, int bc, int fc);
    obs_t o;
    @(posedge clk);
    #1;
    reset          = rs;
    bus.flush      = fl;
    bus.stall      = st;
    bus.bubble     = bu;
    bus.id_valid   = v.valid;
    {bus.ALUSrc, bus.MemtoReg, bus.RegWrite, bus.MemRead, bus.MemWrite,
     bus.JalrSel, bus.jal_signal, bus.Branch, bus.UIOp, bus.ALUOp} = v.ctrl;
    bus.id_pc  = v.pc;  bus.id_rd1 = v.rd1; bus.id_rd2 = v.rd2; bus.id_imm = v.imm;
    bus.id_rs1 = v.rs1; bus.id_rs2 = v.rs2; bus.id_rd  = v.rd;
    bus.id_funct3 = v.f3; bus.id_funct7 = v.f7;
    o.st = e;
    o.bc = 4'(bc);
    o.fc = 4'(fc);
    exp_q.push_back(o);
    tag_q.push_back(cyc + 1);
    nm_q.push_back(nm);
  endtask

  // Monitor: compares whenever the DUT has produced the entry an expectation was queued for.
  initial begin
    obs_t  got;
    obs_t  want;
    string nm;
    int    tag;
    forever begin
      @(posedge clk);
      #3;
      while (tag_q.size() > 0 && tag_q[0] <= cyc) begin
        tag  = tag_q.pop_front();
        want = exp_q.pop_front();
        nm   = nm_q.pop_front();
        got  = sample();
        chk_cnt++;
        if (tag != cyc) begin
          $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d", nm, tag, cyc);
        end else if (got !== want) begin
          $display("FAIL %s: got %h want %h", nm, got, want);
        end else begin
          pass_cnt++;
        end
      end
    end
  end

  initial begin
    stage_t ones, nop, add_i, lw_i, sw_i, add2_i, jal_i, inv_i, inv_e;
    ones   = '1;
    nop    = '0;
    add_i  = mk(1'b1, 12'h202, 32'h40, 32'h11,  32'h22,   32'h0,   5'd1, 5'd2, 5'd5, 3'd0, 7'h00);
    lw_i   = mk(1'b1, 12'hF00, 32'h44, 32'h100, 32'h0,    32'h8,   5'd2, 5'd0, 5'd6, 3'd2, 7'h00);
    sw_i   = mk(1'b1, 12'h880, 32'h48, 32'h100, 32'hDEAD, 32'hC,   5'd2, 5'd7, 5'd0, 3'd2, 7'h00);
    add2_i = mk(1'b1, 12'h202, 32'h4C, 32'h33,  32'h44,   32'h0,   5'd6, 5'd3, 5'd9, 3'd0, 7'h20);
    jal_i  = mk(1'b1, 12'h230, 32'h50, 32'h0,   32'h0,    32'h100, 5'd0, 5'd0, 5'd1, 3'd0, 7'h00);
    inv_i  = mk(1'b0, 12'h280, 32'h54, 32'hCAFE, 32'hBEEF, 32'h4,  5'd3, 5'd4, 5'd8, 3'd1, 7'h01);
    inv_e  = mk(1'b0, 12'h000, 32'h54, 32'hCAFE, 32'hBEEF, 32'h4,  5'd3, 5'd4, 5'd8, 3'd1, 7'h01);

    reset = 1'b0;
    bus.flush = 1'b0; bus.stall = 1'b0; bus.bubble = 1'b0; bus.id_valid = 1'b0;

    step("reset_all_ones_a", ones, 1'b0, 1'b1, 1'b1, 1'b1, nop, 0, 0);
    step("reset_all_ones_b", ones, 1'b0, 1'b1, 1'b1, 1'b1, nop, 0, 0);
    step("load_add",         add_i, 1'b1, 1'b0, 1'b0, 1'b0, add_i, 0, 0);
    step("load_lw",          lw_i,  1'b1, 1'b0, 1'b0, 1'b0, lw_i,  0, 0);
    for (int i = 0; i < 3; i++)
      step("stall_hold_lw",  sw_i,  1'b1, 1'b0, 1'b1, 1'b0, lw_i,  0, 0);
    step("load_sw_after_stall", sw_i, 1'b1, 1'b0, 1'b0, 1'b0, sw_i, 0, 0);
    step("bubble_nop",       add2_i, 1'b1, 1'b0, 1'b0, 1'b1, nop,    1, 0);
    step("load_after_bubble", add2_i, 1'b1, 1'b0, 1'b0, 1'b0, add2_i, 1, 0);
    step("flush_beats_all",  jal_i, 1'b1, 1'b1, 1'b1, 1'b1, nop,   1, 1);
    step("load_jal",         jal_i, 1'b1, 1'b0, 1'b0, 1'b0, jal_i, 1, 1);
    step("stall_ignores_bubble", add_i, 1'b1, 1'b0, 1'b1, 1'b1, jal_i, 1, 1);
    step("flush_only",       add_i, 1'b1, 1'b1, 1'b0, 1'b0, nop,   1, 2);
    step("invalid_masks_ctrl", inv_i, 1'b1, 1'b0, 1'b0, 1'b0, inv_e, 1, 2);

    // Twenty bubbles from bubble_cnt==1: 2..15, then pinned at 15.
    for (int i = 1; i <= 20; i++)
      step("bubble_saturate", add_i, 1'b1, 1'b0, 1'b0, 1'b1, nop, (i + 1 > 15) ? 15 : i + 1, 2);
    step("reset_mid_bubbles", add_i, 1'b0, 1'b0, 1'b0, 1'b1, nop, 0, 0);
    step("bubble_after_reset", add_i, 1'b1, 1'b0, 1'b0, 1'b1, nop, 1, 0);

    step("load_before_flushes", lw_i, 1'b1, 1'b0, 1'b0, 1'b0, lw_i, 1, 0);
    for (int i = 1; i <= 17; i++)
      step("flush_saturate", sw_i, 1'b1, 1'b1, 1'b0, 1'b1, nop, 1, (i > 15) ? 15 : i);
    step("stall_holds_counters", add_i, 1'b1, 1'b0, 1'b1, 1'b1, nop, 1, 15);
    step("reset_mid_stall_flush", add_i, 1'b0, 1'b1, 1'b1, 1'b0, nop, 0, 0);
    step("load_after_reset", add_i, 1'b1, 1'b0, 1'b0, 1'b0, add_i, 0, 0);

    for (int i = 0; i < 10 && tag_q.size() > 0; i++) @(posedge clk);
    #5;
    if (tag_q.size() > 0) begin
      chk_cnt++;
      $display("FAIL drain: %0d expectations never checked, want 0", tag_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
